// File: rtl/aes_pkg.sv
// Shared AES types and helpers. State bytes are addressed in FIPS-197 order:
// byte 0 is the most significant byte of the 128-bit state.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {SB_IDLE, SB_BUSY, SB_DONE} sb_state_e;

  function automatic byte_t get_byte(state_t s, int i);
    logic [6:0] lsb;
    lsb = 7'(8 * (15 - i));
    return s[lsb +: 8];
  endfunction

  function automatic state_t put_byte(state_t s, int i, byte_t b);
    state_t     r;
    logic [6:0] lsb;
    lsb = 7'(8 * (15 - i));
    r = s;
    r[lsb +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/sbox.sv
// Combinational AES forward S-box lookup (one byte in, one byte out).
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry for input x sits at bits [2047-8x -: 8], so the table reads 00..ff left to right.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  assign base = 11'd2040 - {a, 3'b000};
  assign y    = SBOX_TBL[base +: 8];

endmodule

// File: rtl/sub_bytes_serial.sv
// AES SubBytes stage: substitutes a 128-bit state LANES bytes per cycle in a
// working register, then presents the result over a valid/ready handshake.
module sub_bytes_serial #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  import aes_pkg::*;

  localparam int BEATS = 16 / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  sb_state_e       state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  state_t          work_reg;
  state_t          work_sub;
  logic            last_beat;
  byte_t           lane_in  [LANES];
  byte_t           lane_out [LANES];

  assign last_beat = (cnt_reg == CW'(BEATS - 1));
  assign out_state = work_reg;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      SB_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SB_BUSY;
      end
      SB_BUSY: begin
        busy = 1'b1;
        if (last_beat) state_next = SB_DONE;
      end
      SB_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = SB_IDLE;
      end
      default: state_next = SB_IDLE;
    endcase
  end

  // Lane k of beat c reads byte c*LANES+k of the working register.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_in[k] = get_byte(work_reg, int'(cnt_reg) * LANES + k);
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      sbox u_sbox (
        .a (lane_in[gi]),
        .y (lane_out[gi])
      );
    end
  endgenerate

  always_comb begin
    work_sub = work_reg;
    for (int k = 0; k < LANES; k++) begin
      work_sub = put_byte(work_sub, int'(cnt_reg) * LANES + k, lane_out[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SB_IDLE;
      cnt_reg   <= '0;
      work_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        SB_IDLE: begin
          if (in_valid) begin
            work_reg <= in_state;
            cnt_reg  <= '0;
          end
        end
        SB_BUSY: begin
          work_reg <= work_sub;
          cnt_reg  <= last_beat ? '0 : cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Scoreboard bench: three instances (LANES 4, 1, 16); drivers push expected
// results, a negedge monitor pops and compares on each output handshake.
module tb_sub_bytes_serial;

  typedef struct {
    logic [127:0] data;
    int           acc;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   in_valid  = '0;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready = '1;
  logic [2:0]   busy;
  logic [127:0] in_state  [3];
  logic [127:0] out_state [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [2:0]   prev_valid = '0;
  logic [2:0]   prev_ready = '0;
  logic [127:0] prev_state [3];

  logic [2047:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  sub_bytes_serial #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_state(in_state[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0])
  );
  sub_bytes_serial #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_state(in_state[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1])
  );
  sub_bytes_serial #(.LANES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_state(in_state[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_state(out_state[2]), .busy(busy[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int qsize(int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpeek(int d);
    case (d)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic void qpop(int d);
    case (d)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endfunction

  function automatic void qpush(int d, exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic logic [127:0] ref_sub(logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = s[127-8*i -: 8];
      r[127-8*i -: 8] = sbox_tbl[2047-8*int'(b) -: 8];
    end
    return r;
  endfunction

  // Monitor: latency on rising out_valid, data on handshake, stability under backpressure.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        prev_valid[d] = 1'b0;
      end else begin
        if (out_valid[d]) begin
          check($sformatf("dut%0d in_ready low while out_valid", d), {127'd0, in_ready[d]}, 128'd0);
        end
        if (out_valid[d] && !prev_valid[d]) begin
          if (qsize(d) == 0) begin
            check($sformatf("dut%0d unexpected out_valid", d), 128'd1, 128'd0);
          end else begin
            e = qpeek(d);
            check($sformatf("dut%0d latency", d), 128'(cyc - e.acc + 1), 128'(e.lat));
          end
        end
        if (out_valid[d] && prev_valid[d] && !prev_ready[d]) begin
          check($sformatf("dut%0d out_state stable", d), out_state[d], prev_state[d]);
        end
        if (out_valid[d] && out_ready[d]) begin
          if (qsize(d) != 0) begin
            e = qpeek(d);
            check($sformatf("dut%0d out_state", d), out_state[d], e.data);
            $display("[TB] dut%0d out %h", d, out_state[d]);
            qpop(d);
          end
        end
        prev_valid[d] = out_valid[d];
      end
      prev_ready[d] = out_ready[d];
      prev_state[d] = out_state[d];
    end
  end

  // Wait for in_ready (optionally wiggling ignored inputs meanwhile), then present one block.
  task automatic send(int d, logic [127:0] data, logic [127:0] exp, int lat,
                      bit push, bit noise, bit hold, output int acc);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready[d] && n < 300) begin
      if (noise) begin
        in_valid[d] = 1'($urandom_range(0, 1));
        in_state[d] = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[d]) check($sformatf("dut%0d in_ready timeout", d), 128'd0, 128'd1);
    in_valid[d] = 1'b1;
    in_state[d] = data;
    @(posedge clk); #1;
    acc = cyc;
    if (push) begin
      e.data = exp; e.acc = acc; e.lat = lat;
      qpush(d, e);
    end
    if (!hold) in_valid[d] = 1'b0;
    $display("[TB] dut%0d in  %h at cycle %0d", d, data, acc);
  endtask

  task automatic drain(int d);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (qsize(d) != 0) check($sformatf("dut%0d drain timeout", d), 128'd0, 128'd1);
  endtask

  initial begin
    int a1, a2, n;
    logic [127:0] blk;
    for (int d = 0; d < 3; d++) in_state[d] = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d reset in_ready", d), {127'd0, in_ready[d]}, 128'd1);
      check($sformatf("dut%0d reset out_valid", d), {127'd0, out_valid[d]}, 128'd0);
      check($sformatf("dut%0d reset out_state", d), out_state[d], 128'd0);
      check($sformatf("dut%0d reset busy", d), {127'd0, busy[d]}, 128'd0);
    end
    @(posedge clk); #1;

    // FIPS-197 vector and all-zero blocks on each lane width.
    send(0, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816, 5, 1, 0, 0, a1);
    drain(0);
    send(0, 128'h0, {16{8'h63}}, 5, 1, 0, 0, a1);
    send(1, 128'h0, {16{8'h63}}, 17, 1, 0, 0, a1);
    send(2, 128'h0, {16{8'h63}}, 2, 1, 0, 0, a1);
    drain(0); drain(1); drain(2);
    send(2, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816, 2, 1, 0, 0, a1);
    send(1, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816, 17, 1, 0, 0, a1);
    drain(1); drain(2);

    // Backpressure: hold out_ready low for 10 cycles in DONE.
    out_ready[0] = 1'b0;
    send(0, {16{8'h53}}, {16{8'hed}}, 5, 1, 0, 0, a1);
    n = 0;
    while (!out_valid[0] && n < 50) begin @(posedge clk); #1; n++; end
    check("bp out_valid reached", {127'd0, out_valid[0]}, 128'd1);
    repeat (10) begin @(posedge clk); #1; end
    check("bp out_valid held", {127'd0, out_valid[0]}, 128'd1);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp in_ready next cycle", {127'd0, in_ready[0]}, 128'd1);
    check("bp out_valid dropped", {127'd0, out_valid[0]}, 128'd0);

    // Reset in the middle of BUSY (at beat 2): block is discarded.
    send(0, 128'h0123456789abcdef0123456789abcdef, 128'h0, 5, 0, 0, 0, a1);
    @(posedge clk); @(posedge clk); #1;
    check("mid busy asserted", {127'd0, busy[0]}, 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst mid in_ready", {127'd0, in_ready[0]}, 128'd1);
    check("rst mid out_valid", {127'd0, out_valid[0]}, 128'd0);
    check("rst mid out_state", out_state[0], 128'd0);
    check("rst mid busy", {127'd0, busy[0]}, 128'd0);
    @(posedge clk); #1;
    send(0, {16{8'hff}}, {16{8'h16}}, 5, 1, 0, 0, a1);
    drain(0);

    // Back-to-back with in_valid held high.
    send(0, 128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816, 5, 1, 0, 1, a1);
    send(0, {16{8'h53}}, {16{8'hed}}, 5, 1, 0, 0, a2);
    check("b2b accept spacing", 128'(a2 - a1), 128'd6);
    drain(0);

    // Exhaustive 00..ff over 16 blocks with ignored in_valid noise while busy.
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'(b * 16 + i);
      send(0, blk, ref_sub(blk), 5, 1, 1, 0, a1);
    end
    drain(0);

    for (int d = 0; d < 3; d++) check($sformatf("dut%0d queue empty", d), 128'(qsize(d)), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
